// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared board geometry and scanner state type
package board_pkg;

    localparam int NUM_ROWS   = 8;
    localparam int NUM_COLS   = 8;
    localparam int BOARD_BITS = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } scan_state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for asynchronous inputs
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/board_scanner.sv
// rtl/board_scanner.sv - row-strobed 8x8 piece sensor scanner with stability filter
module board_scanner
    import board_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int STABLE_SCANS  = 3,
    parameter int MAX_SCANS     = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [NUM_COLS-1:0]   col_n,
    output logic [NUM_ROWS-1:0]   row_n,
    output logic [BOARD_BITS-1:0] boardState,
    output logic                  done,
    output logic                  unstable
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int MW = $clog2(STABLE_SCANS + 1);
    localparam int CW = $clog2(MAX_SCANS + 1);
    localparam int RW = $clog2(NUM_ROWS);

    scan_state_t           state, state_nxt;
    logic                  load_s;
    logic [NUM_COLS-1:0]   col_s;
    logic [RW-1:0]         row, row_nxt;
    logic [SW-1:0]         settle_cnt, settle_nxt;
    logic [MW-1:0]         match_cnt, match_nxt;
    logic [CW-1:0]         scan_cnt, scan_nxt;
    logic [BOARD_BITS-1:0] scan_buf, prev_buf, buf_nxt;
    logic [NUM_ROWS-1:0]   row_n_nxt;
    logic                  done_nxt;
    logic                  row_end, scan_end, stable_hit, publish, pub_ahead;

    sync2 #(.WIDTH(1)) u_sync_load (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (load),
        .q       (load_s)
    );

    sync2 #(.WIDTH(NUM_COLS)) u_sync_col (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (col_n),
        .q       (col_s)
    );

    always_comb begin
        row_end    = (state == SCAN) && (settle_cnt == SW'(SETTLE_CYCLES));
        scan_end   = row_end && (row == RW'(NUM_ROWS - 1));
        stable_hit = (match_cnt >= MW'(STABLE_SCANS));
        publish    = (state == SCAN) && !load_s && (stable_hit || scan_cnt >= CW'(MAX_SCANS));
        buf_nxt    = scan_buf;
        buf_nxt[int'(row)*NUM_COLS +: NUM_COLS] = ~col_s;
        if (scan_cnt == '0 || buf_nxt != prev_buf)
            match_nxt = MW'(1);
        else if (match_cnt == MW'(STABLE_SCANS))
            match_nxt = match_cnt;
        else
            match_nxt = match_cnt + MW'(1);
        scan_nxt  = (scan_cnt == CW'(MAX_SCANS)) ? scan_cnt : scan_cnt + CW'(1);
        // a publish will follow this scan, so keep the rows released meanwhile
        pub_ahead = scan_end && (match_nxt >= MW'(STABLE_SCANS) || scan_nxt >= CW'(MAX_SCANS));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_s) state_nxt = LOAD;
            LOAD:    if (!load_s) state_nxt = SCAN;
            SCAN:    if (load_s) state_nxt = LOAD;
                     else if (publish) state_nxt = DONE;
            DONE:    if (load_s) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        row_nxt    = row;
        settle_nxt = settle_cnt;
        if (state != SCAN || state_nxt != SCAN) begin
            row_nxt    = '0;
            settle_nxt = '0;
        end else if (row_end) begin
            row_nxt    = row + RW'(1);
            settle_nxt = '0;
        end else begin
            settle_nxt = settle_cnt + SW'(1);
        end
        row_n_nxt = '1;
        if (state_nxt == SCAN && !pub_ahead)
            row_n_nxt = ~(NUM_ROWS'(1) << row_nxt);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row        <= '0;
            settle_cnt <= '0;
            match_cnt  <= '0;
            scan_cnt   <= '0;
            scan_buf   <= '0;
            prev_buf   <= '0;
            row_n      <= '1;
            done       <= 1'b0;
            unstable   <= 1'b0;
            boardState <= '0;
        end else begin
            row        <= row_nxt;
            settle_cnt <= settle_nxt;
            row_n      <= row_n_nxt;
            done       <= done_nxt;
            if (state == LOAD) begin
                match_cnt <= '0;
                scan_cnt  <= '0;
            end else if (row_end) begin
                scan_buf <= buf_nxt;
                if (scan_end) begin
                    prev_buf  <= buf_nxt;
                    match_cnt <= match_nxt;
                    scan_cnt  <= scan_nxt;
                end
            end
            if (publish) begin
                boardState <= scan_buf;
                unstable   <= !stable_hit;
            end
        end
    end

endmodule

// File: doc/board_scanner.md
BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16, clocks a row is driven before its columns are sampled; legal minimum 4.
REQ-002 Parameter STABLE_SCANS, default 3, consecutive identical full scans required before publishing.
REQ-003 Parameter MAX_SCANS, default 255, scan limit before a forced publish.
REQ-004 Port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-005 Port reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port load, input, 1, asynchronous request from the MCU; high requests a new board capture.
REQ-007 Port col_n, input, 8, asynchronous sensor column lines; low means a piece is present.
REQ-008 Port row_n, output, 8, row drive; one-hot low selects a row, all-high means idle.
REQ-009 Port boardState, output, 64, published board; bit row*8+col is 1 when a piece is present.
REQ-010 Port done, output, 1, high when boardState is published and frozen for the SPI shifter.
REQ-011 Port unstable, output, 1, high when the current publish was forced by MAX_SCANS.

Function
REQ-012 Both load and col_n SHALL pass through two-flop synchronizers before any use.
REQ-013 The FSM SHALL have the states IDLE, LOAD, SCAN and DONE.
REQ-014 IDLE SHALL drive done=0 and row_n=8'hFF, and on synchronized load=1 go to LOAD.
REQ-015 LOAD SHALL drive done=0, row_n=8'hFF, and clear the match and scan counters; on synchronized load=0 it SHALL go to SCAN with row=0.
REQ-016 In SCAN, each row SHALL be driven for exactly SETTLE_CYCLES+1 clocks; the synchronized ~col_n SHALL be captured into scan buffer bits [row*8+7:row*8] on the last of those clocks.
REQ-017 The row index SHALL advance 0 to 7, so one full scan takes 8*(SETTLE_CYCLES+1) clocks.
REQ-018 At the end of row 7:
  - if scan_cnt is 0 or the buffer differs from the previous scan, match_cnt SHALL be set to 1; otherwise match_cnt SHALL increment;
  - the buffer SHALL then be copied to the previous-scan register and scan_cnt SHALL increment.
REQ-019 When match_cnt reaches STABLE_SCANS, the block SHALL publish in the next clock: boardState is loaded from the buffer, unstable=0, done=1, row_n=8'hFF, and the state goes to DONE.
REQ-020 If scan_cnt reaches MAX_SCANS without stability, the block SHALL publish the latest scan with unstable=1.
REQ-021 In DONE, boardState and done SHALL be held constant; on synchronized load=1 the state SHALL go to LOAD with done=0 in the same clock.
REQ-022 boardState SHALL change only on the publish clock and never while done=1.
REQ-023 If load rises during SCAN, the scan SHALL abort, go to LOAD, set row_n=8'hFF, and leave boardState unchanged.
REQ-024 The counters SHALL saturate and never wrap; the widths SHALL be sized from the parameters.
REQ-025 row_n SHALL be registered and glitch-free, with never more than one bit low.

Reset
REQ-026 On reset_n=0, state SHALL be IDLE, row_n=8'hFF, boardState=0, done=0, unstable=0, and all counters, scan buffers and synchronizers SHALL be 0.
REQ-027 Reset asserted mid-scan SHALL take effect immediately and asynchronously; release SHALL be synchronous to clk.

Structure
REQ-028 A shared package board_pkg SHALL hold NUM_ROWS=8, NUM_COLS=8, BOARD_BITS=64 and the scanner state enum.
REQ-029 The two-flop synchronizer SHALL be a separate sub-module sync2, parameterized by width and instanced for load and col_n.
REQ-030 board_scanner SHALL feed the SPI shifter through boardState and done directly, with no extra pipeline stage.

Verification (SETTLE_CYCLES=4, STABLE_SCANS=3, MAX_SCANS=8, so 40 clocks per scan)
REQ-031 Reset: assert reset_n=0 mid-scan -> row_n=8'hFF, done=0 and boardState=0 within the same cycle.
REQ-032 Static board (row 0 col_n=8'h00, others 8'hFF), load pulse -> done rises 120..126 clocks after load falls, with boardState=64'h0000_0000_0000_00FF and unstable=0.
REQ-033 Bit 9 toggles every scan -> after 8 scans done=1 and unstable=1, with boardState equal to the 8th scan.
REQ-034 Load raised during row 5 -> row_n=8'hFF, done=0 and boardState unchanged; a full 3-scan capture follows load falling.
REQ-035 col_n changes while done=1 -> boardState holds its value bit-for-bit until the next load.
REQ-036 row_n monitor across all tests -> never more than one bit low, and each row is low for exactly 5 clocks.
